// File: rtl/sync_debouncer.sv
// rtl/sync_debouncer.sv - glitch filter with edge pulses, long-hold pulse and glitch counter
//
// Sits right after the input synchronizer. A level change is accepted only
// after DEBOUNCE_CYCLES consecutive identical samples; a shorter excursion
// is dropped and counted in glitch_cnt.

module sync_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_in,
  input  logic       enable,
  input  logic       clr_glitch,
  output logic       level_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       long_hold,
  output logic       pending,
  output logic [7:0] glitch_cnt
);

  // Counter widths; guarded so an illegal parameter still elaborates far
  // enough to reach the fatal check below.
  localparam int DW = (DEBOUNCE_CYCLES >= 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int HW = (HOLD_CYCLES >= 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  // Count value held in a PEND state just before the accepting sample.
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $fatal(1, "sync_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $fatal(1, "sync_debouncer: HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_e;

  localparam state_e RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  state_e          state_q, state_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            hold_armed_q, hold_armed_d;
  logic            long_hold_q, long_hold_d;
  logic [7:0]      glitch_q, glitch_d;

  logic            accept_rise;
  logic            accept_fall;
  logic            reject;

  // Qualification FSM: decides acceptance, rejection and the next state.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    reject      = 1'b0;

    if (!enable) begin
      // Frozen: abandon any candidate silently and restart from zero later.
      db_cnt_d = '0;
      if (state_q == PEND_HI) state_d = STABLE_LO;
      if (state_q == PEND_LO) state_d = STABLE_HI;
    end else begin
      case (state_q)
        STABLE_LO: begin
          if (sync_in) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept_rise = 1'b1;
            end else begin
              state_d  = PEND_HI;
              db_cnt_d = DW'(1);
            end
          end
        end
        PEND_HI: begin
          if (sync_in) begin
            if (db_cnt_q == DB_LAST) accept_rise = 1'b1;
            else                     db_cnt_d    = db_cnt_q + DW'(1);
          end else begin
            state_d  = STABLE_LO;
            db_cnt_d = '0;
            reject   = 1'b1;
          end
        end
        STABLE_HI: begin
          if (!sync_in) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept_fall = 1'b1;
            end else begin
              state_d  = PEND_LO;
              db_cnt_d = DW'(1);
            end
          end
        end
        PEND_LO: begin
          if (!sync_in) begin
            if (db_cnt_q == DB_LAST) accept_fall = 1'b1;
            else                     db_cnt_d    = db_cnt_q + DW'(1);
          end else begin
            state_d  = STABLE_HI;
            db_cnt_d = '0;
            reject   = 1'b1;
          end
        end
        default: begin
          state_d  = RESET_STATE;
          db_cnt_d = '0;
        end
      endcase
    end

    if (accept_rise) begin
      state_d  = STABLE_HI;
      db_cnt_d = '0;
      level_d  = 1'b1;
      rise_d   = 1'b1;
    end
    if (accept_fall) begin
      state_d  = STABLE_LO;
      db_cnt_d = '0;
      level_d  = 1'b0;
      fall_d   = 1'b1;
    end
  end

  // Long-hold timing: armed by an accepted rise, counts high cycles, fires once.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    hold_armed_d = hold_armed_q;
    long_hold_d  = 1'b0;

    if (accept_rise) begin
      hold_cnt_d   = '0;
      hold_armed_d = 1'b1;
    end else if (accept_fall) begin
      // The press ended; a late count on this edge must not fire long_hold.
      hold_armed_d = 1'b0;
    end else if (enable && level_q && hold_armed_q && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d  = hold_cnt_q + HW'(1);
      long_hold_d = (hold_cnt_d == HOLD_MAX);
    end
  end

  // Glitch counter: saturating increment on rejection, clear has priority.
  always_comb begin
    glitch_d = glitch_q;
    if (clr_glitch) begin
      glitch_d = 8'd0;
    end else if (reject && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_STATE;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Registered level and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Hold counter, arm flag and long-hold pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      hold_armed_q <= 1'b0;
      long_hold_q  <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      hold_armed_q <= hold_armed_d;
      long_hold_q  <= long_hold_d;
    end
  end

  // Diagnostic glitch counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign long_hold  = long_hold_q;
  assign pending    = (state_q == PEND_HI) || (state_q == PEND_LO);
  assign glitch_cnt = glitch_q;

endmodule

// File: doc/sync_debouncer.md
Name: sync_debouncer

Overview:
- Single-clock stage directly downstream of the multi-flop input synchronizer.
- Takes the already-synchronized level and rejects glitches shorter than a programmable window.
- Presents a clean level plus one-cycle rise/fall pulses and a long-hold indication.
- Counts rejected glitches for diagnostics. Used on buttons, straps and slow external status lines.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical samples required to accept a level change; legal range >= 1.
- HOLD_CYCLES, 1000: cycles level_out must stay high, counted from the rise, before long_hold fires; legal range >= 1.
- INIT_LEVEL, 0: value of level_out and the idle FSM state after reset.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- sync_in, input, 1: synchronized input level; already in the clk domain, sampled every cycle.
- enable, input, 1: 1 = filter runs; 0 = filter frozen (see Behaviour).
- clr_glitch, input, 1: synchronous clear of glitch_cnt.
- level_out, output, 1: debounced level (registered).
- rise_pulse, output, 1: one-cycle pulse on an accepted 0->1 change.
- fall_pulse, output, 1: one-cycle pulse on an accepted 1->0 change.
- long_hold, output, 1: one-cycle pulse when the high level has lasted HOLD_CYCLES.
- pending, output, 1: 1 while a candidate change is being qualified.
- glitch_cnt, output, 8: saturating count of rejected candidate changes.

Behaviour:
- Reset (async assert, sync release by the upstream reset scheme):
  - FSM = STABLE_HI if INIT_LEVEL = 1, else STABLE_LO; level_out = INIT_LEVEL.
  - rise_pulse = fall_pulse = long_hold = pending = 0; glitch_cnt = 0; all counters = 0.
- FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. pending = 1 in PEND_* only.
- Debounce counter: clog2(DEBOUNCE_CYCLES+1) bits, counts consecutive samples of the candidate level.
- STABLE_LO:
  - sync_in = 1 -> PEND_HI with count = 1.
  - If DEBOUNCE_CYCLES = 1, go directly to STABLE_HI and accept on that same edge.
- PEND_HI:
  - sync_in = 1 -> count += 1. When the edge captures the DEBOUNCE_CYCLES-th consecutive 1 -> STABLE_HI; level_out = 1 and rise_pulse = 1 after that edge.
  - sync_in = 0 -> back to STABLE_LO; glitch_cnt += 1; level_out unchanged.
- STABLE_HI / PEND_LO: mirror image of the above; acceptance sets level_out = 0 and fall_pulse = 1.
- Latency: level_out changes after the edge that captures the DEBOUNCE_CYCLES-th consecutive sample of the new level. For sync_in = 1 captured at edges 1..4 with DEBOUNCE_CYCLES = 4, level_out = 1 after edge 4.
- Pulses:
  - rise_pulse and fall_pulse are high for exactly one cycle and never both in one cycle.
  - Pulses do not re-fire while a level is held.
- Hold counter: clog2(HOLD_CYCLES+1) bits.
  - Cleared to 0 on the rise-acceptance edge; increments each cycle while level_out = 1 (including in PEND_LO).
  - long_hold pulses once, after the edge where the counter reaches HOLD_CYCLES, then saturates. No re-fire until a new rise.
  - If a fall is accepted before HOLD_CYCLES, long_hold never fires for that press.
  - A rejected PEND_LO glitch does not restart or stop the hold counter.
- enable = 0:
  - PEND_* returns to the matching STABLE_* state; debounce counter cleared; not counted as a glitch.
  - level_out holds; rise_pulse, fall_pulse and long_hold are forced to 0; hold counter frozen.
  - On enable returning to 1, qualification restarts from count 0.
- glitch_cnt:
  - Saturates at 255.
  - clr_glitch = 1 clears it. When a clear and an increment fall on the same edge, the clear wins (result 0).
- Reset asserted mid-qualification or mid-hold: all state returns to reset values immediately; no pulse is emitted.
- Elaboration: DEBOUNCE_CYCLES < 1 or HOLD_CYCLES < 1 is a fatal error.

Test Plan:
1. DEBOUNCE_CYCLES = 4, enable = 1. sync_in 0 -> 1, held 10 cycles -> level_out = 1 after the 4th high sample; rise_pulse high for exactly that 1 cycle; pending high for the 3 preceding cycles; glitch_cnt = 0.
2. Glitch rejection: sync_in high for 3 cycles, then low -> level_out stays 0, no rise_pulse, glitch_cnt = 1. Repeat 300 times -> glitch_cnt saturates at 255.
3. Long hold: HOLD_CYCLES = 10, stable high held 25 cycles -> long_hold pulses once, 10 cycles after rise_pulse. A 3-cycle low glitch at cycle 6 does not delay long_hold. Fall after 5 cycles of high -> no long_hold.
4. Release: from stable high, sync_in low for 4 cycles -> fall_pulse once, level_out = 0. Low for only 2 cycles -> no change, glitch_cnt += 1.
5. Enable and clear: enable dropped during PEND_HI at count 3 -> back to STABLE_LO, glitch_cnt unchanged. clr_glitch on the same edge as a rejection -> glitch_cnt = 0.
6. Reset: assert rst_n = 0 mid-PEND_HI and mid-hold -> outputs return to INIT_LEVEL/0 asynchronously, no pulses. Repeat with INIT_LEVEL = 1 and DEBOUNCE_CYCLES = 1 (accept on the first differing sample).
